// File: rtl/fft_out_serializer.sv
// fft_out_serializer: collects 8 groups of SIZE_GRP complex samples per
// frame into a ping-pong pair of banks and streams each completed frame
// out one sample per cycle in natural bin order over a valid/ready port.
module fft_out_serializer #(
  parameter int DATA_WD  = 16,
  parameter int SIZE_GRP = 8,
  localparam int CNT_W   = 3 + $clog2(SIZE_GRP)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        grp_val_i,
  input  logic [2:0]                  grp_idx_i,
  input  logic [SIZE_GRP*DATA_WD-1:0] grp_dat_re_i,
  input  logic [SIZE_GRP*DATA_WD-1:0] grp_dat_im_i,
  output logic                        grp_rdy_o,
  output logic                        err_o,
  output logic                        val_o,
  input  logic                        rdy_i,
  output logic [DATA_WD-1:0]          fft_dat_re_o,
  output logic [DATA_WD-1:0]          fft_dat_im_o,
  output logic [CNT_W-1:0]            idx_o,
  output logic                        sof_o,
  output logic                        eof_o
);

  localparam int LANE_W = $clog2(SIZE_GRP);
  localparam int GRP_W  = SIZE_GRP * DATA_WD;
  localparam logic [CNT_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  // Bank state and pointers
  bank_st_e         bank_st_q [2];
  bank_st_e         bank_st_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [2:0]       exp_grp_q, exp_grp_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  // Set once sample 63 of rd_bank has been loaded into the output register;
  // from then on reads are fetched from the other bank so the next frame
  // can follow without a bubble, while rd_bank stays owned until 63 leaves.
  logic             drained_q, drained_d;

  // Registered outputs
  logic             err_q, err_d;
  logic             val_q, val_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic [DATA_WD-1:0] re_q, re_d;
  logic [DATA_WD-1:0] im_q, im_d;
  logic [CNT_W-1:0]   idx_q, idx_d;

  // Storage: one row per {bank, group}, a whole group wide
  logic [GRP_W-1:0] mem_re [16];
  logic [GRP_W-1:0] mem_im [16];

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic             src_bank;
  logic [3:0]       rd_addr;
  logic [GRP_W-1:0] rd_row_re;
  logic [GRP_W-1:0] rd_row_im;
  logic [DATA_WD-1:0] rd_lane_re [SIZE_GRP];
  logic [DATA_WD-1:0] rd_lane_im [SIZE_GRP];
  logic [DATA_WD-1:0] rd_sel_re;
  logic [DATA_WD-1:0] rd_sel_im;

  logic grp_acc;
  logic grp_hit;
  logic out_load;
  logic xfer_last;
  logic src_full;

  assign grp_rdy_o = rst && (bank_st_q[wr_bank_q] != BANK_FULL);

  assign wr_addr   = {wr_bank_q, exp_grp_q};
  assign src_bank  = drained_q ? ~rd_bank_q : rd_bank_q;
  assign rd_addr   = {src_bank, rd_cnt_q[CNT_W-1 -: 3]};
  assign rd_row_re = mem_re[rd_addr];
  assign rd_row_im = mem_im[rd_addr];

  generate
    for (genvar gi = 0; gi < SIZE_GRP; gi++) begin : g_lane
      assign rd_lane_re[gi] = rd_row_re[gi*DATA_WD +: DATA_WD];
      assign rd_lane_im[gi] = rd_row_im[gi*DATA_WD +: DATA_WD];
    end
  endgenerate

  assign rd_sel_re = rd_lane_re[rd_cnt_q[LANE_W-1:0]];
  assign rd_sel_im = rd_lane_im[rd_cnt_q[LANE_W-1:0]];

  // Next-state: group write side, bank bookkeeping and output register load
  always_comb begin
    bank_st_d = bank_st_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    exp_grp_d = exp_grp_q;
    rd_cnt_d  = rd_cnt_q;
    drained_d = drained_q;
    val_d     = val_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    re_d      = re_q;
    im_d      = im_q;
    idx_d     = idx_q;

    // Write side: only the expected group is stored; anything else is dropped
    grp_acc = grp_val_i && grp_rdy_o;
    grp_hit = grp_acc && (grp_idx_i == exp_grp_q);
    wr_en   = grp_hit;
    err_d   = grp_acc && !grp_hit;
    if (grp_hit) begin
      exp_grp_d = exp_grp_q + 3'd1;
      if (exp_grp_q == 3'd7) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
      end
    end

    // Read side: the bank is released only when its last sample leaves
    out_load  = !val_q || rdy_i;
    xfer_last = val_q && rdy_i && eof_q;
    src_full  = (bank_st_q[src_bank] == BANK_FULL);
    if (xfer_last) begin
      bank_st_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d            = ~rd_bank_q;
      drained_d            = 1'b0;
    end
    if (out_load) begin
      val_d = src_full;
      if (src_full) begin
        re_d     = rd_sel_re;
        im_d     = rd_sel_im;
        idx_d    = rd_cnt_q;
        sof_d    = (rd_cnt_q == '0);
        eof_d    = (rd_cnt_q == LAST_IDX);
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (rd_cnt_q == LAST_IDX) begin
          drained_d = 1'b1;
        end
      end else begin
        sof_d = 1'b0;
        eof_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      exp_grp_q    <= '0;
      rd_cnt_q     <= '0;
      drained_q    <= 1'b0;
      err_q        <= 1'b0;
      val_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      re_q         <= '0;
      im_q         <= '0;
      idx_q        <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      exp_grp_q    <= exp_grp_d;
      rd_cnt_q     <= rd_cnt_d;
      drained_q    <= drained_d;
      err_q        <= err_d;
      val_q        <= val_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      re_q         <= re_d;
      im_q         <= im_d;
      idx_q        <= idx_d;
    end
  end

  // Group storage write; contents are never cleared, bank state guards reads
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_addr] <= grp_dat_re_i;
      mem_im[wr_addr] <= grp_dat_im_i;
    end
  end

  assign err_o        = err_q;
  assign val_o        = val_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign fft_dat_re_o = re_q;
  assign fft_dat_im_o = im_q;
  assign idx_o        = idx_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: groups are fed from a queue, a model of the
// write side pushes expected samples to a scoreboard on each completed
// frame, and a negedge monitor checks transfers, hold stability and err_o.
module tb_fft_out_serializer;

  localparam int DW = 16;
  localparam int SG = 8;

  logic           clk;
  logic           rst;
  logic           grp_val_i;
  logic [2:0]     grp_idx_i;
  logic [SG*DW-1:0] grp_dat_re_i;
  logic [SG*DW-1:0] grp_dat_im_i;
  logic           grp_rdy_o;
  logic           err_o;
  logic           val_o;
  logic           rdy_i;
  logic [DW-1:0]  fft_dat_re_o;
  logic [DW-1:0]  fft_dat_im_o;
  logic [5:0]     idx_o;
  logic           sof_o;
  logic           eof_o;

  fft_out_serializer #(.DATA_WD(DW), .SIZE_GRP(SG)) dut (
    .clk          (clk),
    .rst          (rst),
    .grp_val_i    (grp_val_i),
    .grp_idx_i    (grp_idx_i),
    .grp_dat_re_i (grp_dat_re_i),
    .grp_dat_im_i (grp_dat_im_i),
    .grp_rdy_o    (grp_rdy_o),
    .err_o        (err_o),
    .val_o        (val_o),
    .rdy_i        (rdy_i),
    .fft_dat_re_o (fft_dat_re_o),
    .fft_dat_im_o (fft_dat_im_o),
    .idx_o        (idx_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       idx;
    logic [SG*DW-1:0] re;
    logic [SG*DW-1:0] im;
  } grp_t;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [5:0]    idx;
  } smp_t;

  typedef struct {
    int   idx;
    bit   junk;
    logic exp_rdy;
    logic exp_err;
  } vec_t;

  grp_t feed [$];
  smp_t exp_q [$];
  logic [DW-1:0] m_re [64];
  logic [DW-1:0] m_im [64];
  logic [2:0]    m_exp;
  logic          err_pend;
  logic          prev_stall;
  logic [63:0]   prev_out;

  int n_tests;
  int n_fail;
  int n_xfer;
  int tick_n;
  int acc_tick;
  int eof_tick;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, req, tick_n);
    end
  endtask

  function automatic logic [DW-1:0] mk_re(input int fid, input int n);
    return DW'(fid * 64 + n);
  endfunction

  function automatic logic [DW-1:0] mk_im(input int fid, input int n);
    return DW'((n * 1031 + fid * 77) ^ 32'h8000);
  endfunction

  task automatic push_group(input int fid, input int g, input bit junk, input bit rnd);
    grp_t h;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    h.idx = 3'(g);
    h.re  = '0;
    h.im  = '0;
    for (int l = 0; l < SG; l++) begin
      r = rnd ? DW'($urandom) : mk_re(fid, g * SG + l);
      i = rnd ? DW'($urandom) : mk_im(fid, g * SG + l);
      if (junk) begin
        r = r ^ 16'h5A5A;
        i = i ^ 16'hA5A5;
      end
      h.re[l*DW +: DW] = r;
      h.im[l*DW +: DW] = i;
    end
    feed.push_back(h);
  endtask

  task automatic push_frame(input int fid, input bit rnd);
    for (int g = 0; g < 8; g++) push_group(fid, g, 1'b0, rnd);
  endtask

  // Negedge observer: handshake model, err_o, hold stability, scoreboard
  task automatic monitor();
    grp_t h;
    smp_t e;
    logic [63:0] cur;
    if (rst == 1'b0) begin
      exp_q.delete();
      feed.delete();
      m_exp      = '0;
      err_pend   = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    check("err_o", err_o, err_pend);
    err_pend = 1'b0;
    if (grp_val_i && grp_rdy_o && feed.size() > 0) begin
      h = feed.pop_front();
      acc_tick = tick_n;
      if (h.idx == m_exp) begin
        for (int l = 0; l < SG; l++) begin
          m_re[int'(m_exp) * SG + l] = h.re[l*DW +: DW];
          m_im[int'(m_exp) * SG + l] = h.im[l*DW +: DW];
        end
        if (m_exp == 3'd7) begin
          for (int n = 0; n < 64; n++) begin
            e.re  = m_re[n];
            e.im  = m_im[n];
            e.idx = 6'(n);
            exp_q.push_back(e);
          end
        end
        m_exp = m_exp + 3'd1;
      end else begin
        err_pend = 1'b1;
      end
    end
    cur = {23'd0, val_o, fft_dat_re_o, fft_dat_im_o, idx_o, sof_o, eof_o};
    if (prev_stall) check("hold", cur, prev_out);
    if (val_o && rdy_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL xfer_unexpected: got idx %0d re %0h expected no sample", idx_o, fft_dat_re_o);
      end else begin
        e = exp_q.pop_front();
        check("sample", {fft_dat_re_o, fft_dat_im_o, idx_o, sof_o, eof_o},
              {e.re, e.im, e.idx, (e.idx == 6'd0), (e.idx == 6'd63)});
      end
      n_xfer++;
      if (eof_o) eof_tick = tick_n;
    end
    prev_stall = val_o && !rdy_i;
    prev_out   = cur;
  endtask

  task automatic tick();
    if (feed.size() > 0) begin
      grp_val_i    = 1'b1;
      grp_idx_i    = feed[0].idx;
      grp_dat_re_i = feed[0].re;
      grp_dat_im_i = feed[0].im;
    end else begin
      grp_val_i = 1'b0;
    end
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    tick_n++;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && feed.size() == 0 && !val_o) break;
      tick();
    end
    check(name, exp_q.size() + feed.size(), 0);
  endtask

  vec_t vecs [10];
  int   x0;
  bit   got;
  bit   found;

  initial begin
    n_tests = 0; n_fail = 0; n_xfer = 0; tick_n = 0; acc_tick = 0; eof_tick = 0;
    m_exp = '0; err_pend = 1'b0; prev_stall = 1'b0; prev_out = '0;
    rst = 1'b0; rdy_i = 1'b0; grp_val_i = 1'b0; grp_idx_i = '0;
    grp_dat_re_i = '0; grp_dat_im_i = '0;

    // Out-of-order table: dropped groups carry junk so a stray write shows up
    vecs[0] = '{0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{3, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{4, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{5, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{6, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{7, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) tick();
    check("reset_out", {val_o, sof_o, eof_o, err_o, idx_o, fft_dat_re_o, fft_dat_im_o}, '0);
    check("reset_rdy", grp_rdy_o, 1'b0);
    rst = 1'b1;
    #1;
    check("rdy_after_release", grp_rdy_o, 1'b1);
    $display("[TB] reset done");

    // Single frame, lane value 8*g+lane, downstream always ready
    rdy_i = 1'b1;
    push_frame(0, 1'b0);
    repeat (8) tick();
    check("a_groups_taken", feed.size(), 0);
    check("a_val_before", val_o, 1'b0);
    tick();
    check("a_first_out", {val_o, idx_o, sof_o, fft_dat_re_o}, {1'b1, 6'd0, 1'b1, 16'd0});
    x0 = n_xfer;
    repeat (64) tick();
    check("a_64_contig", n_xfer - x0, 64);
    check("a_idle_after", val_o, 1'b0);
    $display("[TB] frame 0 streamed: %0d samples", n_xfer - x0);

    // Three frames with downstream stalled, then release
    rdy_i = 1'b0;
    push_frame(1, 1'b0);
    push_frame(2, 1'b0);
    repeat (16) tick();
    check("b_two_frames_in", feed.size(), 0);
    push_frame(3, 1'b0);
    repeat (4) tick();
    check("b_rdy_low", grp_rdy_o, 1'b0);
    check("b_hold_idx0", {val_o, idx_o, sof_o}, {1'b1, 6'd0, 1'b1});
    check("b_no_accept", feed.size(), 8);
    rdy_i = 1'b1;
    x0 = n_xfer;
    got = 1'b0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (!got && feed.size() < 8) begin
        got = 1'b1;
        check("b_rdy_rise", acc_tick, eof_tick + 1);
      end
    end
    check("b_accept_seen", got, 1'b1);
    check("b_128_contig", n_xfer - x0, 128);
    wait_idle("b_drain");
    $display("[TB] stalled frames streamed: %0d samples", n_xfer - x0);

    // Out-of-order groups from the table
    for (int i = 0; i < 10; i++) begin
      push_group(4, vecs[i].idx, vecs[i].junk, 1'b0);
      check($sformatf("c_rdy_%0d", i), grp_rdy_o, vecs[i].exp_rdy);
      tick();
      check($sformatf("c_err_%0d", i), err_o, vecs[i].exp_err);
      $display("[TB] group idx %0d sent, err_o=%0b", vecs[i].idx, err_o);
    end
    wait_idle("c_drain");

    // Random backpressure over two random frames
    push_frame(0, 1'b1);
    push_frame(0, 1'b1);
    x0 = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && feed.size() == 0 && !val_o && i > 0) break;
      rdy_i = 1'($urandom_range(0, 1));
      tick();
    end
    rdy_i = 1'b1;
    check("d_drain", exp_q.size() + feed.size(), 0);
    check("d_count", n_xfer - x0, 128);
    $display("[TB] random backpressure: %0d samples", n_xfer - x0);

    // Reset in the middle of a frame with a second frame queued
    push_frame(5, 1'b0);
    push_frame(6, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (val_o && idx_o == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    check("e_reached_30", found, 1'b1);
    rst = 1'b0;
    #1;
    check("e_rdy_in_rst", grp_rdy_o, 1'b0);
    tick();
    check("e_out_reset", {val_o, sof_o, eof_o, err_o, idx_o, fft_dat_re_o, fft_dat_im_o}, '0);
    check("e_rdy_after", grp_rdy_o, 1'b0);
    rst = 1'b1;
    x0 = n_xfer;
    repeat (80) tick();
    check("e_no_output", n_xfer - x0, 0);
    push_frame(7, 1'b0);
    wait_idle("e_drain");
    check("e_fresh_frame", n_xfer - x0, 64);
    $display("[TB] post-reset frame: %0d samples", n_xfer - x0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
